// File: rtl/obstacle_spawner.sv
// Obstacle spawner: watches the obstacle down-counter for expiry, raises LFSR-typed spawn requests
// and scrolls the live obstacle. Optional macro SPAWNER_SPEEDUP_EN: speed +1 every eight accepted spawns.
module obstacle_spawner #(
    parameter logic [9:0] SCREEN_X  = 10'd639,
    parameter logic [3:0] SPEED     = 4'd4,
    parameter logic [3:0] MAX_SPEED = 4'd12,
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       game_run,
    input  logic       game_over,
    input  logic       frame_tick,
    input  logic [8:0] count,
    input  logic       spawn_ready,
    output logic [1:0] load_value,
    output logic       load_en,
    output logic       spawn_valid,
    output logic [1:0] obs_type,
    output logic [9:0] obs_x,
    output logic       obs_active
);

    localparam int unsigned X_W    = 10;
    localparam int unsigned SPD_W  = 4;
    localparam int unsigned LFSR_W = 8;
    localparam int unsigned TYPE_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SPAWN,
        S_SCROLL,
        S_HALT
    } state_t;

    state_t              state, state_nxt;
    logic [LFSR_W-1:0]   lfsr;
    logic [SPD_W-1:0]    speed;
    logic                pending, pending_nxt;
    logic                expiry;
    logic                load_en_nxt, spawn_valid_nxt, obs_active_nxt;
    logic [TYPE_W-1:0]   load_value_nxt, obs_type_nxt;
    logic [X_W-1:0]      obs_x_nxt;

    assign expiry = (count == '0);

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; frozen while halted
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (state != S_HALT) begin
            lfsr <= {lfsr[LFSR_W-2:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

`ifdef SPAWNER_SPEEDUP_EN
    logic [2:0] spawn_cnt;
    logic       accept;

    assign accept = (state == S_SPAWN) && spawn_valid && spawn_ready && game_run && !game_over;

    // Speed steps up on every eighth accepted spawn, saturating at the ceiling
    always_ff @(posedge clock) begin
        if (reset) begin
            speed     <= SPEED;
            spawn_cnt <= '0;
        end else if (state == S_IDLE) begin
            speed     <= SPEED;
            spawn_cnt <= '0;
        end else if (accept) begin
            spawn_cnt <= spawn_cnt + 3'd1;
            if (spawn_cnt == 3'd7 && speed < MAX_SPEED) begin
                speed <= speed + 4'd1;
            end
        end
    end
`else
    assign speed = (SPEED > MAX_SPEED) ? MAX_SPEED : SPEED;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        load_en_nxt     = load_en;
        load_value_nxt  = load_value;
        spawn_valid_nxt = spawn_valid;
        obs_type_nxt    = obs_type;
        obs_x_nxt       = obs_x;
        obs_active_nxt  = obs_active;
        pending_nxt     = pending;

        unique case (state)
            S_IDLE: begin
                load_en_nxt = 1'b1;
                if (game_run && !game_over) begin
                    state_nxt   = S_ARM;
                    load_en_nxt = 1'b0;
                end
            end
            S_HALT: begin
                load_en_nxt = 1'b1;
                if (!game_over && !game_run) begin
                    state_nxt       = S_IDLE;
                    obs_active_nxt  = 1'b0;
                    obs_x_nxt       = '0;
                    pending_nxt     = 1'b0;
                    spawn_valid_nxt = 1'b0;
                end
            end
            default: begin
                load_en_nxt = 1'b0;
                if (game_over) begin
                    state_nxt   = S_HALT;
                    load_en_nxt = 1'b1;
                end else if (!game_run) begin
                    state_nxt       = S_IDLE;
                    load_en_nxt     = 1'b1;
                    obs_active_nxt  = 1'b0;
                    pending_nxt     = 1'b0;
                    spawn_valid_nxt = 1'b0;
                end else begin
                    case (state)
                        S_ARM: begin
                            if (expiry) begin
                                state_nxt       = S_SPAWN;
                                spawn_valid_nxt = 1'b1;
                                obs_type_nxt    = lfsr[3:2];
                                load_value_nxt  = lfsr[1:0];
                            end
                        end
                        S_SPAWN: begin
                            if (spawn_valid && spawn_ready) begin
                                state_nxt       = S_SCROLL;
                                spawn_valid_nxt = 1'b0;
                                obs_x_nxt       = SCREEN_X;
                                obs_active_nxt  = 1'b1;
                                load_en_nxt     = 1'b1;
                            end
                        end
                        S_SCROLL: begin
                            pending_nxt = pending | expiry;
                            if (frame_tick) begin
                                if (obs_x > X_W'(speed)) begin
                                    obs_x_nxt = obs_x - X_W'(speed);
                                end else begin
                                    // Despawn clamps to zero; an expiry this cycle counts as pending
                                    obs_x_nxt      = '0;
                                    obs_active_nxt = 1'b0;
                                    if (pending || expiry) begin
                                        state_nxt       = S_SPAWN;
                                        pending_nxt     = 1'b0;
                                        spawn_valid_nxt = 1'b1;
                                        obs_type_nxt    = lfsr[3:2];
                                        load_value_nxt  = lfsr[1:0];
                                    end else begin
                                        state_nxt = S_ARM;
                                    end
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            load_en     <= 1'b1;
            load_value  <= '0;
            spawn_valid <= 1'b0;
            obs_type    <= '0;
            obs_x       <= '0;
            obs_active  <= 1'b0;
            pending     <= 1'b0;
        end else begin
            load_en     <= load_en_nxt;
            load_value  <= load_value_nxt;
            spawn_valid <= spawn_valid_nxt;
            obs_type    <= obs_type_nxt;
            obs_x       <= obs_x_nxt;
            obs_active  <= obs_active_nxt;
            pending     <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner; spawn type/reload expectations come from a
// reference LFSR and are queued when the expiry is driven, then popped when spawn_valid rises.
module tb_obstacle_spawner;

    logic       clock = 1'b0;
    logic       reset, game_run, game_over, frame_tick, spawn_ready;
    logic [8:0] count;
    logic [1:0] load_value, obs_type;
    logic       load_en, spawn_valid, obs_active;
    logic [9:0] obs_x;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] typ;
        logic [1:0] ld;
    } spawn_exp_t;

    spawn_exp_t exp_q[$];
    logic [7:0] m_lfsr;
    logic       m_halt = 1'b0;

    obstacle_spawner dut (
        .clock      (clock),
        .reset      (reset),
        .game_run   (game_run),
        .game_over  (game_over),
        .frame_tick (frame_tick),
        .count      (count),
        .spawn_ready(spawn_ready),
        .load_value (load_value),
        .load_en    (load_en),
        .spawn_valid(spawn_valid),
        .obs_type   (obs_type),
        .obs_x      (obs_x),
        .obs_active (obs_active)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Reference LFSR; m_halt is set by the tests while the block is known to be halted
    always @(posedge clock) begin
        if (reset) m_lfsr <= 8'hA5;
        else if (!m_halt) m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0;
    endtask

    task automatic handshake();
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
    endtask

    task automatic push_exp();
        spawn_exp_t e;
        e.typ = m_lfsr[3:2];
        e.ld  = m_lfsr[1:0];
        exp_q.push_back(e);
    endtask

    task automatic pop_exp(output spawn_exp_t e, output bit ok);
        ok = (exp_q.size() != 0);
        e  = '0;
        if (ok) e = exp_q.pop_front();
    endtask

    // Drives an expiry while ARM is expected and checks the resulting spawn request
    task automatic spawn_from_arm(input string tag);
        spawn_exp_t e;
        bit ok;
        count = 9'd0;
        push_exp();
        step();
        count = 9'd5;
        pop_exp(e, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_queue: got empty expected entry", tag); end
        checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b expected 1", tag, spawn_valid); end
        checks++; if (obs_type !== e.typ) begin errors++; $display("FAIL %s_type: got %0d expected %0d", tag, obs_type, e.typ); end
        checks++; if (load_value !== e.ld) begin errors++; $display("FAIL %s_load: got %0d expected %0d", tag, load_value, e.ld); end
    endtask

    task automatic test_reset();
        reset = 1'b1; game_run = 1'b0; game_over = 1'b0; frame_tick = 1'b0;
        spawn_ready = 1'b0; count = 9'd5;
        step(); step();
        checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL reset_load_en: got %b expected 1", load_en); end
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", spawn_valid); end
        checks++; if (obs_x !== 10'd0) begin errors++; $display("FAIL reset_obs_x: got %0d expected 0", obs_x); end
        checks++; if (obs_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", obs_active); end
        checks++; if (load_value !== 2'd0) begin errors++; $display("FAIL reset_load_value: got %0d expected 0", load_value); end
        checks++; if (obs_type !== 2'd0) begin errors++; $display("FAIL reset_type: got %0d expected 0", obs_type); end
        reset = 1'b0;
    endtask

    task automatic test_spawn_handshake();
        spawn_exp_t e;
        bit ok;
        game_run = 1'b1; count = 9'd5;
        step();
        checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL arm_load_en: got %b expected 0", load_en); end
        count = 9'd4;
        step();
        count = 9'd0;
        push_exp();
        step();
        count = 9'd5;
        pop_exp(e, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hs_queue: got empty expected entry"); end
        // Ready held low three cycles; an expiry in the middle must be dropped
        for (int i = 0; i < 3; i++) begin
            checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL hs_valid_hold: got %b expected 1 (cycle %0d)", spawn_valid, i); end
            checks++; if (obs_type !== e.typ || load_value !== e.ld) begin
                errors++; $display("FAIL hs_payload: got type %0d load %0d expected type %0d load %0d", obs_type, load_value, e.typ, e.ld);
            end
            count = (i == 1) ? 9'd0 : 9'd5;
            step();
        end
        count = 9'd5;
        handshake();
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL hs_valid_drop: got %b expected 0", spawn_valid); end
        checks++; if (obs_active !== 1'b1) begin errors++; $display("FAIL hs_active: got %b expected 1", obs_active); end
        checks++; if (obs_x !== 10'd639) begin errors++; $display("FAIL hs_obs_x: got %0d expected 639", obs_x); end
        checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL hs_load_pulse: got %b expected 1", load_en); end
        step();
        checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL hs_load_end: got %b expected 0", load_en); end
    endtask

    task automatic test_scroll();
        tick(159);
        checks++; if (obs_x !== 10'd3) begin errors++; $display("FAIL scroll_159: got %0d expected 3", obs_x); end
        checks++; if (obs_active !== 1'b1) begin errors++; $display("FAIL scroll_active: got %b expected 1", obs_active); end
        tick(1);
        checks++; if (obs_active !== 1'b0) begin errors++; $display("FAIL despawn_active: got %b expected 0", obs_active); end
        checks++; if (obs_x !== 10'd0) begin errors++; $display("FAIL despawn_obs_x: got %0d expected 0", obs_x); end
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL despawn_no_pending: got %b expected 0", spawn_valid); end
        spawn_from_arm("rearm");
        handshake();
        checks++; if (obs_x !== 10'd639) begin errors++; $display("FAIL rearm_obs_x: got %0d expected 639", obs_x); end
    endtask

    task automatic test_pending();
        spawn_exp_t e;
        bit ok;
        tick(10);
        count = 9'd0; step(); count = 9'd5;
        tick(5);
        count = 9'd0; step(); count = 9'd5;
        tick(144);
        checks++; if (obs_x !== 10'd3) begin errors++; $display("FAIL pend_pre: got %0d expected 3", obs_x); end
        push_exp();
        tick(1);
        pop_exp(e, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pend_queue: got empty expected entry"); end
        checks++; if (obs_active !== 1'b0) begin errors++; $display("FAIL pend_despawn: got %b expected 0", obs_active); end
        checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL pend_valid: got %b expected 1", spawn_valid); end
        checks++; if (obs_type !== e.typ || load_value !== e.ld) begin
            errors++; $display("FAIL pend_payload: got type %0d load %0d expected type %0d load %0d", obs_type, load_value, e.typ, e.ld);
        end
        handshake();
        checks++; if (obs_x !== 10'd639) begin errors++; $display("FAIL pend_obs_x: got %0d expected 639", obs_x); end
        tick(160);
        checks++; if (obs_active !== 1'b0) begin errors++; $display("FAIL pend2_despawn: got %b expected 0", obs_active); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL pend_single: got %b expected 0 (cycle %0d)", spawn_valid, i); end
            step();
        end
    endtask

    task automatic test_simultaneous();
        spawn_exp_t e;
        bit ok;
        spawn_from_arm("sim_arm");
        handshake();
        tick(159);
        count = 9'd0;
        push_exp();
        tick(1);
        count = 9'd5;
        pop_exp(e, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sim_queue: got empty expected entry"); end
        checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL sim_valid: got %b expected 1", spawn_valid); end
        checks++; if (obs_type !== e.typ || load_value !== e.ld) begin
            errors++; $display("FAIL sim_payload: got type %0d load %0d expected type %0d load %0d", obs_type, load_value, e.typ, e.ld);
        end
        handshake();
        checks++; if (obs_x !== 10'd639) begin errors++; $display("FAIL sim_obs_x: got %0d expected 639", obs_x); end
    endtask

    task automatic test_freeze();
        tick(59);
        checks++; if (obs_x !== 10'd403) begin errors++; $display("FAIL freeze_pre: got %0d expected 403", obs_x); end
        // Tick coincident with game_over must be discarded
        game_over = 1'b1; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0; m_halt = 1'b1;
        checks++; if (obs_x !== 10'd403) begin errors++; $display("FAIL freeze_coincident: got %0d expected 403", obs_x); end
        checks++; if (obs_active !== 1'b1) begin errors++; $display("FAIL freeze_active: got %b expected 1", obs_active); end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++; if (obs_x !== 10'd403) begin errors++; $display("FAIL freeze_hold: got %0d expected 403 (tick %0d)", obs_x, i); end
            checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL freeze_load_en: got %b expected 1 (tick %0d)", load_en, i); end
        end
        game_over = 1'b0; game_run = 1'b0;
        step();
        m_halt = 1'b0;
        checks++; if (obs_active !== 1'b0) begin errors++; $display("FAIL unfreeze_active: got %b expected 0", obs_active); end
        checks++; if (obs_x !== 10'd0) begin errors++; $display("FAIL unfreeze_obs_x: got %0d expected 0", obs_x); end
        checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL unfreeze_load_en: got %b expected 1", load_en); end
        // LFSR must have stood still during the halt
        game_run = 1'b1;
        step();
        spawn_from_arm("post_halt");
        handshake();
    endtask

    task automatic test_reset_mid();
        tick(10);
        reset = 1'b1; spawn_ready = 1'b1; frame_tick = 1'b1;
        step(); step();
        spawn_ready = 1'b0; frame_tick = 1'b0;
        checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL rst_mid_load_en: got %b expected 1", load_en); end
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", spawn_valid); end
        checks++; if (obs_active !== 1'b0) begin errors++; $display("FAIL rst_mid_active: got %b expected 0", obs_active); end
        checks++; if (obs_x !== 10'd0) begin errors++; $display("FAIL rst_mid_obs_x: got %0d expected 0", obs_x); end
        checks++; if (load_value !== 2'd0) begin errors++; $display("FAIL rst_mid_load_value: got %0d expected 0", load_value); end
        reset = 1'b0;
        step();
        spawn_from_arm("post_reset");
        handshake();
    endtask

`ifdef SPAWNER_SPEEDUP_EN
    task automatic test_speedup();
        game_run = 1'b0; step();
        game_run = 1'b1; step();
        for (int k = 0; k < 9; k++) begin
            spawn_from_arm("speedup");
            handshake();
            if (k == 8) break;
            for (int n = 0; n < 200 && obs_active; n++) tick(1);
            checks++; if (obs_active !== 1'b0) begin errors++; $display("FAIL speedup_despawn: got %b expected 0 (spawn %0d)", obs_active, k); end
        end
        checks++; if (obs_x !== 10'd639) begin errors++; $display("FAIL speedup_start: got %0d expected 639", obs_x); end
        tick(1);
        checks++; if (obs_x !== 10'd634) begin errors++; $display("FAIL speedup_step: got %0d expected 634", obs_x); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_spawn_handshake();
        test_scroll();
        test_pending();
        test_simultaneous();
        test_freeze();
        test_reset_mid();
`ifdef SPAWNER_SPEEDUP_EN
        test_speedup();
`endif
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain: got %0d expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
